// File: rtl/clock_div_scheduler.sv
// clock_div_scheduler
//   Run-time controller for a power-of-two clock divider (/2, /4, /8, /16 with the
//   default SEL_W). Produces single-cycle enable ticks and a 50% duty divided waveform
//   from the system clock. Ratio changes arrive over a valid/ready handshake and are
//   applied only at a period boundary, so no output period is ever cut short or stretched.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   en         in   1 = run the divider, 0 = stop at the next period boundary
//   cfg_valid  in   new ratio request valid
//   cfg_sel    in   requested ratio select, divide ratio = 2^(cfg_sel+1)
//   cfg_ready  out  request can be accepted this cycle (IDLE or RUN)
//   tick       out  one-cycle pulse on the last cycle of each divided period
//   div_out    out  50% duty divided waveform
//   cur_sel    out  ratio select currently in effect
//   busy       out  high while the divider is counting (RUN, SWITCH, STOP)

module clock_div_scheduler #(
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned RESET_SEL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             tick,
    output logic             div_out,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy
);

    localparam int unsigned CNT_W = 2 ** SEL_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StSwitch,
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;

    logic [CNT_W-1:0]   bnd_mask;
    logic               bnd;
    logic               hs;

    // Low (cur_sel+1) bits of the counter all ones marks the last cycle of a period.
    always_comb begin
        bnd_mask = '0;
        for (int i = 0; i < int'(CNT_W); i++) begin
            bnd_mask[i] = (i <= int'(cur_sel_q));
        end
    end

    assign bnd       = ((cnt_q & bnd_mask) == bnd_mask);
    assign busy      = (state_q != StIdle);
    assign cfg_ready = (state_q == StIdle) || (state_q == StRun);
    assign hs        = cfg_valid && cfg_ready;
    assign tick      = bnd && busy;
    assign div_out   = cnt_q[cur_sel_q] && busy;
    assign cur_sel   = cur_sel_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Applied directly so a same-cycle en starts with the new ratio.
                if (hs) begin
                    cur_sel_d = cfg_sel;
                end
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (hs) begin
                    pend_sel_d = cfg_sel;
                    state_d    = en ? StSwitch : StStop;
                end else if (!en) begin
                    state_d = StStop;
                end
            end
            StSwitch: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bnd) begin
                    cur_sel_d = pend_sel_q;
                    cnt_d     = '0;
                    state_d   = en ? StRun : StIdle;
                end
            end
            StStop: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Re-enable keeps counting so the running period is not disturbed.
                if (en) begin
                    state_d = StRun;
                end else if (bnd) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_sel_q  <= SEL_W'(RESET_SEL);
            pend_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
        end
    end

endmodule

// File: tb/tb_clock_div_scheduler.sv
// Bench for clock_div_scheduler: expected tick cycles are queued when stimulus is
// issued; a monitor pops one per observed tick and compares the cycle number.

module tb_clock_div_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cfg_valid;
    logic [1:0] cfg_sel;
    logic       cfg_ready;
    logic       tick;
    logic       div_out;
    logic [1:0] cur_sel;
    logic       busy;

    clock_div_scheduler #(
        .SEL_W     (2),
        .RESET_SEL (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .div_out   (div_out),
        .cur_sel   (cur_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned exp_q[$];
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_tick(input int unsigned c);
        exp_q.push_back(c);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int unsigned target);
        while (cyc < target) wait_cycles(1);
    endtask

    // Monitor: every observed tick must match the next queued cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            checks++;
            $display("FAIL missed_tick: no tick seen, expected at cycle %0d (now %0d)",
                     exp_q[0], cyc);
            void'(exp_q.pop_front());
        end
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_tick: tick at cycle %0d, expected none", cyc);
            end else begin
                chk("tick_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end", cyc);
        $fatal(1);
    end

    int unsigned c1, d0, e0, f0;

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = 2'd0;

        // Reset held 3 cycles.
        wait_cycles(3);
        chk("rst_tick", tick, 0);
        chk("rst_div_out", div_out, 0);
        chk("rst_cur_sel", cur_sel, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        wait_cycles(1);

        // /8 configured in IDLE, then enabled.
        cfg_valid = 1'b1;
        cfg_sel   = 2'd2;
        wait_cycles(1);
        cfg_valid = 1'b0;
        chk("idle_cfg_cur_sel", cur_sel, 2);
        chk("idle_busy", busy, 0);
        c1 = cyc;
        en = 1'b1;
        expect_tick(c1 + 8);
        expect_tick(c1 + 16);
        expect_tick(c1 + 24);
        expect_tick(c1 + 32);
        go_to(c1 + 1); chk("div8_c0", div_out, 0); chk("run_busy", busy, 1);
        go_to(c1 + 4); chk("div8_c3", div_out, 0);
        go_to(c1 + 5); chk("div8_c4", div_out, 1);
        go_to(c1 + 8); chk("div8_c7", div_out, 1);
        go_to(c1 + 9); chk("div8_c8", div_out, 0);
        go_to(c1 + 24); en = 1'b0;
        go_to(c1 + 28); chk("stop_cfg_ready", cfg_ready, 0); chk("stop_busy", busy, 1);
        go_to(c1 + 33); chk("stopped_busy", busy, 0); chk("stopped_div", div_out, 0);
        chk("stopped_cfg_ready", cfg_ready, 1);

        // /4 with same-cycle cfg+en, then /16 accepted mid-period.
        d0        = cyc;
        cfg_valid = 1'b1;
        cfg_sel   = 2'd1;
        en        = 1'b1;
        expect_tick(d0 + 4);
        expect_tick(d0 + 8);
        go_to(d0 + 1); cfg_valid = 1'b0; chk("same_cycle_cur_sel", cur_sel, 1);
        go_to(d0 + 6);
        chk("run_cfg_ready", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd3;
        expect_tick(d0 + 24);
        expect_tick(d0 + 40);
        go_to(d0 + 7); cfg_valid = 1'b0;
        chk("switch_cfg_ready", cfg_ready, 0); chk("switch_cur_sel", cur_sel, 1);
        go_to(d0 + 8); chk("switch_bnd_cfg_ready", cfg_ready, 0);
        go_to(d0 + 9); chk("post_switch_cfg_ready", cfg_ready, 1);
        chk("post_switch_cur_sel", cur_sel, 3);
        go_to(d0 + 16); chk("div16_c7", div_out, 0);
        go_to(d0 + 17); chk("div16_c8", div_out, 1);

        // /16 stop requested at cnt=5.
        go_to(d0 + 46); en = 1'b0;
        expect_tick(d0 + 56);
        go_to(d0 + 50); chk("stop16_cfg_ready", cfg_ready, 0); chk("stop16_busy", busy, 1);
        go_to(d0 + 57); chk("stop16_idle_busy", busy, 0); chk("stop16_div", div_out, 0);

        // Stop at cnt=5, re-enable at cnt=9: no gap.
        e0 = cyc;
        en = 1'b1;
        expect_tick(e0 + 16);
        go_to(e0 + 6); en = 1'b0;
        go_to(e0 + 10);
        chk("restop_cfg_ready", cfg_ready, 0);
        en = 1'b1;
        expect_tick(e0 + 32);
        go_to(e0 + 11); chk("resume_cfg_ready", cfg_ready, 1);
        go_to(e0 + 32); en = 1'b0;
        expect_tick(e0 + 48);
        go_to(e0 + 49); chk("resume_idle_busy", busy, 0);

        // /2, cfg accepted on the boundary cycle.
        f0        = cyc;
        cfg_valid = 1'b1;
        cfg_sel   = 2'd0;
        en        = 1'b1;
        expect_tick(f0 + 2);
        expect_tick(f0 + 4);
        expect_tick(f0 + 6);
        go_to(f0 + 1); cfg_valid = 1'b0; chk("div2_cur_sel", cur_sel, 0);
        go_to(f0 + 4);
        chk("bnd_cfg_ready", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd2;
        expect_tick(f0 + 14);
        go_to(f0 + 5); cfg_valid = 1'b0; chk("bnd_switch_cfg_ready", cfg_ready, 0);
        go_to(f0 + 6); chk("bnd_extra_cur_sel", cur_sel, 0);
        go_to(f0 + 7); chk("bnd_applied_cur_sel", cur_sel, 2);

        // Reset while in SWITCH with /16 pending.
        go_to(f0 + 16);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd3;
        go_to(f0 + 17); cfg_valid = 1'b0;
        chk("pend_cfg_ready", cfg_ready, 0); chk("pend_busy", busy, 1);
        go_to(f0 + 18); reset = 1'b1;
        go_to(f0 + 19);
        chk("mid_rst_cur_sel", cur_sel, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        chk("mid_rst_div", div_out, 0);
        reset = 1'b0;
        expect_tick(f0 + 21);
        expect_tick(f0 + 23);
        expect_tick(f0 + 25);
        go_to(f0 + 23); en = 1'b0;
        go_to(f0 + 25); chk("no_pend_cur_sel", cur_sel, 0);
        go_to(f0 + 26); chk("final_busy", busy, 0);

        wait_cycles(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
